alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle controller that sequences the 8-bit 6502 ALU for one arithmetic or logic operation per request.
- Latches the operands and the op, then drives the ALU select strobes, carry-in and operands.
- For decimal-mode ADC/SBC it runs a second correction pass through the ALU.
- Returns the registered result and the N/V/Z/C flags to the CPU core under a START/DONE handshake.

Parameters:
- None. The datapath is fixed at 8 bits and the op width at 4 bits.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  request strobe; sampled only when BUSY=0
- OP  in  4  operation code (package constants)
- OPA  in  8  operand A (accumulator or memory)
- OPB  in  8  operand B
- CIN  in  1  current status-register carry
- DMODE  in  1  current status-register D flag
- BUSY  out  1  high in EXEC and ADJ
- DONE  out  1  one-cycle pulse; RESULT and flags valid while high
- RESULT  out  8  registered result
- FLAG_N, FLAG_V, FLAG_Z, FLAG_C  out  1 each  registered flags
- FLAGS_UPD  out  4  {N,V,Z,C} write mask, valid with DONE
- ALU_A, ALU_B  out  8 each  operands to the ALU
- ALU_SUMS, ALU_ANDS, ALU_ORS, ALU_EORS, ALU_SRS, ALU_BCDS  out  1 each  ALU function selects; at most one of SUMS/ANDS/ORS/EORS/SRS high
- ALU_CIN  out  1  ALU carry-in
- ALU_RESULT  in  8  ALU result (combinational)
- ALU_OF, ALU_COUT, ALU_HCOUT  in  1 each  ALU overflow, carry, half carry

Behaviour:
- Reset: state IDLE; every output 0, including all ALU strobes.
- Reset mid-operation aborts the operation; no DONE is issued.
- States: IDLE, EXEC, ADJ, FIN.
- IDLE or FIN with START=1: latch OP, OPA, OPB, CIN and DMODE, then go to EXEC. START while BUSY=1 is ignored. FIN accepts START, so back-to-back operations are possible.
- EXEC: drive the ALU from the latched values and capture its outputs at the clock edge.
  - Go to ADJ if decimal ADC/SBC, otherwise FIN.
- ADJ: ALU_A = the captured binary result, ALU_B = the correction value, SUMS=1, ALU_CIN=0. Capture the result, then go to FIN.
- FIN: DONE=1 for one cycle; then IDLE unless START is high.
- Latency: DONE is high 2 cycles after the START edge for binary operations and 3 cycles for decimal.
- Op mapping (ALU drive / flags updated):
  - ADC: SUMS, B=OPB, cin=CIN / NVZC
  - SBC: SUMS, B=~OPB, cin=CIN / NVZC
  - AND, ORA, EOR: ANDS, ORS, EORS respectively / NZ
  - LSR: SRS, cin=0 / NZC
  - ROR: SRS, cin=CIN / NZC. For SRS the ALU's COUT carries the shifted-out bit 0.
  - ASL: SUMS, A=B=OPA, cin=0 / NZC
  - ROL: SUMS, A=B=OPA, cin=CIN / NZC
  - CMP: SUMS, B=~OPB, cin=1 / NZC; RESULT=OPA, unchanged
  - INC: SUMS, B=0x00, cin=1 / NZ
  - DEC: SUMS, B=0xFF, cin=0 / NZ
  - Undefined OP: no ALU strobe, RESULT=OPA, FLAGS_UPD=0, DONE still issued.
- Flag rules:
  - N = R[7]; Z = (R==0), computed on the final result, or on the ALU sum for CMP.
  - V = ALU_OF from the EXEC pass.
  - C = ALU_COUT from EXEC, except for decimal ADC, where C = hi_adj.
- Decimal ADC correction (R = binary result):
  - lo_adj = HCOUT | (R[3:0] > 9)
  - hi_adj = COUT | (R > 0x99)
  - correction = {hi_adj ? 6 : 0, lo_adj ? 6 : 0}
- Decimal SBC correction:
  - lo_adj = ~HCOUT; hi_adj = ~COUT
  - correction = (hi_adj ? 0xA0 : 0x00) + (lo_adj ? 0xFA : 0x00), modulo 256
  - C keeps the EXEC value.
- ALU_BCDS is held 0; the controller performs the decimal adjust itself.
- All additions wrap modulo 256.

Optional Feature:
- Macro ALU_SEQ_DECIMAL_EN.
- Defined: decimal ADC/SBC take the ADJ pass as above.
- Undefined (2A03-style core): DMODE is ignored, ADJ is unreachable and not synthesised, and all ADC/SBC operations complete in 2 cycles as binary.

Decomposition:
- Package alu_seq_pkg holds:
  - OP encodings: ADC=0 SBC=1 AND=2 ORA=3 EOR=4 LSR=5 ROR=6 ASL=7 ROL=8 CMP=9 INC=10 DEC=11
  - state encoding
  - FLAGS_UPD mask constants
  - correction constants 0x06, 0x60, 0xFA, 0xA0
- One combinational sub-module, alu_seq_dec_adj, computes lo_adj, hi_adj, the correction byte and the decimal carry from R, COUT, HCOUT and the op.

Test Plan (bench uses a behavioural ALU model):
- Binary ADC 0x50+0x50, CIN=0 -> RESULT=0xA0, N=1 V=1 Z=0 C=0, FLAGS_UPD=1111, DONE 2 cycles after START.
- SBC 0x00-0x01, CIN=1, D=0 -> RESULT=0xFF, N=1 C=0 Z=0.
- Decimal ADC 0x09+0x01 -> RESULT=0x10, C=0, DONE at 3 cycles.
- Decimal ADC 0x99+0x01 -> RESULT=0x00, C=1, Z=1.
- CMP 0x40 vs 0x40 -> Z=1 C=1 N=0, RESULT=0x40, FLAGS_UPD=1011.
- START pulsed during BUSY -> ignored.
- RST asserted in ADJ -> no DONE, all outputs 0, next START runs normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the 6502 ALU sequencer.
//   - op encodings, FSM state encoding, {N,V,Z,C} write masks
//   - decimal correction constants
//   - alu_drive_t and helpers that build the ALU drive for a pass
package alu_seq_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADC = 4'd0;
    localparam logic [OP_W-1:0] OP_SBC = 4'd1;
    localparam logic [OP_W-1:0] OP_AND = 4'd2;
    localparam logic [OP_W-1:0] OP_ORA = 4'd3;
    localparam logic [OP_W-1:0] OP_EOR = 4'd4;
    localparam logic [OP_W-1:0] OP_LSR = 4'd5;
    localparam logic [OP_W-1:0] OP_ROR = 4'd6;
    localparam logic [OP_W-1:0] OP_ASL = 4'd7;
    localparam logic [OP_W-1:0] OP_ROL = 4'd8;
    localparam logic [OP_W-1:0] OP_CMP = 4'd9;
    localparam logic [OP_W-1:0] OP_INC = 4'd10;
    localparam logic [OP_W-1:0] OP_DEC = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ADJ  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // Write masks, bit order {N,V,Z,C}
    localparam logic [3:0] UPD_NONE = 4'b0000;
    localparam logic [3:0] UPD_NZ   = 4'b1010;
    localparam logic [3:0] UPD_NZC  = 4'b1011;
    localparam logic [3:0] UPD_NVZC = 4'b1111;

    localparam logic [DATA_W-1:0] CORR_LO_ADD = 8'h06;
    localparam logic [DATA_W-1:0] CORR_HI_ADD = 8'h60;
    localparam logic [DATA_W-1:0] CORR_LO_SUB = 8'hFA;
    localparam logic [DATA_W-1:0] CORR_HI_SUB = 8'hA0;

    typedef struct packed {
        logic              sums;
        logic              ands;
        logic              ors;
        logic              eors;
        logic              srs;
        logic              cin;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_drive_t;

    // ALU drive for the main (EXEC) pass of an op.
    function automatic alu_drive_t alu_drive(input logic [OP_W-1:0] op,
                                             input logic [DATA_W-1:0] opa,
                                             input logic [DATA_W-1:0] opb,
                                             input logic cin);
        alu_drive_t d;
        d   = '0;
        d.a = opa;
        case (op)
            OP_ADC: begin d.sums = 1'b1; d.b = opb;   d.cin = cin;  end
            OP_SBC: begin d.sums = 1'b1; d.b = ~opb;  d.cin = cin;  end
            OP_AND: begin d.ands = 1'b1; d.b = opb;                 end
            OP_ORA: begin d.ors  = 1'b1; d.b = opb;                 end
            OP_EOR: begin d.eors = 1'b1; d.b = opb;                 end
            OP_LSR: begin d.srs  = 1'b1;                            end
            OP_ROR: begin d.srs  = 1'b1;               d.cin = cin;  end
            OP_ASL: begin d.sums = 1'b1; d.b = opa;                 end
            OP_ROL: begin d.sums = 1'b1; d.b = opa;   d.cin = cin;  end
            OP_CMP: begin d.sums = 1'b1; d.b = ~opb;  d.cin = 1'b1; end
            OP_INC: begin d.sums = 1'b1; d.b = 8'h00; d.cin = 1'b1; end
            OP_DEC: begin d.sums = 1'b1; d.b = 8'hFF;               end
            default: ; // undefined op: no strobe, result passes OPA through
        endcase
        return d;
    endfunction

    // ALU drive for the decimal correction pass: R + correction, no carry-in.
    function automatic alu_drive_t adj_drive(input logic [DATA_W-1:0] r,
                                             input logic [DATA_W-1:0] corr);
        alu_drive_t d;
        d      = '0;
        d.sums = 1'b1;
        d.a    = r;
        d.b    = corr;
        return d;
    endfunction

    function automatic logic [3:0] flags_mask(input logic [OP_W-1:0] op);
        case (op)
            OP_ADC, OP_SBC:                 return UPD_NVZC;
            OP_AND, OP_ORA, OP_EOR,
            OP_INC, OP_DEC:                 return UPD_NZ;
            OP_LSR, OP_ROR, OP_ASL, OP_ROL,
            OP_CMP:                         return UPD_NZC;
            default:                        return UPD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_dec_adj.sv
// alu_seq_dec_adj: combinational BCD correction for decimal ADC/SBC.
//   r_i       binary result of the EXEC pass
//   cout_i    ALU carry out of the EXEC pass
//   hcout_i   ALU half carry of the EXEC pass
//   is_sbc_i  1 for SBC, 0 for ADC
//   lo_adj_o  low nibble needs correcting
//   hi_adj_o  high nibble needs correcting
//   corr_o    correction byte added in the ADJ pass
//   dec_c_o   final carry flag for the decimal op
module alu_seq_dec_adj
    import alu_seq_pkg::*;
(
    input  logic [DATA_W-1:0] r_i,
    input  logic              cout_i,
    input  logic              hcout_i,
    input  logic              is_sbc_i,
    output logic              lo_adj_o,
    output logic              hi_adj_o,
    output logic [DATA_W-1:0] corr_o,
    output logic              dec_c_o
);

    always_comb begin
        lo_adj_o = 1'b0;
        hi_adj_o = 1'b0;
        corr_o   = '0;
        dec_c_o  = cout_i;
        if (is_sbc_i) begin
            // A borrow out of a nibble shows up as a missing carry.
            lo_adj_o = ~hcout_i;
            hi_adj_o = ~cout_i;
            corr_o   = (hi_adj_o ? CORR_HI_SUB : 8'h00) + (lo_adj_o ? CORR_LO_SUB : 8'h00);
            dec_c_o  = cout_i;
        end else begin
            lo_adj_o = hcout_i | (r_i[3:0] > 4'd9);
            hi_adj_o = cout_i | (r_i > 8'h99);
            corr_o   = (hi_adj_o ? CORR_HI_ADD : 8'h00) | (lo_adj_o ? CORR_LO_ADD : 8'h00);
            dec_c_o  = hi_adj_o;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences the 8-bit 6502 ALU for one op per START/DONE
// handshake (IDLE -> EXEC -> [ADJ] -> FIN).
//   CLK, RST           clock, async active-high reset
//   START, OP, OPA, OPB, CIN, DMODE   request (sampled when BUSY=0)
//   BUSY, DONE         status; DONE is a one-cycle pulse, outputs valid with it
//   RESULT, FLAG_*     registered result and flags; FLAGS_UPD = {N,V,Z,C} mask
//   ALU_*              registered drive to the ALU / its combinational returns
// Handshake: START is accepted on a rising edge where state is IDLE or FIN;
// it is ignored while BUSY=1. DONE rises 2 cycles (binary) or 3 cycles
// (decimal) after the accepting edge's cycle and RESULT/FLAG_*/FLAGS_UPD are
// valid while DONE=1.
// Build option: define ALU_SEQ_DECIMAL_EN to enable the decimal ADJ pass;
// without it DMODE is ignored and ADC/SBC are always binary.
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [OP_W-1:0]   OP,
    input  logic [DATA_W-1:0] OPA,
    input  logic [DATA_W-1:0] OPB,
    input  logic              CIN,
    input  logic              DMODE,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] RESULT,
    output logic              FLAG_N,
    output logic              FLAG_V,
    output logic              FLAG_Z,
    output logic              FLAG_C,
    output logic [3:0]        FLAGS_UPD,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    output logic              ALU_SUMS,
    output logic              ALU_ANDS,
    output logic              ALU_ORS,
    output logic              ALU_EORS,
    output logic              ALU_SRS,
    output logic              ALU_BCDS,
    output logic              ALU_CIN,
    input  logic [DATA_W-1:0] ALU_RESULT,
    input  logic              ALU_OF,
    input  logic              ALU_COUT,
    input  logic              ALU_HCOUT
);

    state_t            state_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] opa_q;
    alu_drive_t        drv_q;

    logic              op_def;
    logic [DATA_W-1:0] exec_result;

    assign ALU_A    = drv_q.a;
    assign ALU_B    = drv_q.b;
    assign ALU_SUMS = drv_q.sums;
    assign ALU_ANDS = drv_q.ands;
    assign ALU_ORS  = drv_q.ors;
    assign ALU_EORS = drv_q.eors;
    assign ALU_SRS  = drv_q.srs;
    assign ALU_CIN  = drv_q.cin;
    assign ALU_BCDS = 1'b0; // decimal adjust is done here, not in the ALU

    assign op_def = (flags_mask(op_q) != UPD_NONE);
    // CMP and undefined ops leave the accumulator value unchanged.
    assign exec_result = (op_q == OP_CMP || !op_def) ? opa_q : ALU_RESULT;

`ifdef ALU_SEQ_DECIMAL_EN
    logic              dmode_q;
    logic              dec_pass;
    logic              lo_adj;
    logic              hi_adj;
    logic [DATA_W-1:0] corr;
    logic              dec_c;
    logic              unused_adj;

    alu_seq_dec_adj u_dec_adj (
        .r_i      (ALU_RESULT),
        .cout_i   (ALU_COUT),
        .hcout_i  (ALU_HCOUT),
        .is_sbc_i (op_q == OP_SBC),
        .lo_adj_o (lo_adj),
        .hi_adj_o (hi_adj),
        .corr_o   (corr),
        .dec_c_o  (dec_c)
    );

    assign unused_adj = lo_adj ^ hi_adj;
    assign dec_pass   = dmode_q && (op_q == OP_ADC || op_q == OP_SBC);
`else
    logic unused_dec;
    assign unused_dec = DMODE ^ ALU_HCOUT;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            opa_q     <= '0;
            drv_q     <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            RESULT    <= '0;
            FLAG_N    <= 1'b0;
            FLAG_V    <= 1'b0;
            FLAG_Z    <= 1'b0;
            FLAG_C    <= 1'b0;
            FLAGS_UPD <= '0;
`ifdef ALU_SEQ_DECIMAL_EN
            dmode_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_FIN: begin
                    DONE <= 1'b0;
                    if (START) begin
                        op_q    <= OP;
                        opa_q   <= OPA;
`ifdef ALU_SEQ_DECIMAL_EN
                        dmode_q <= DMODE;
`endif
                        drv_q   <= alu_drive(OP, OPA, OPB, CIN);
                        BUSY    <= 1'b1;
                        state_q <= ST_EXEC;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    FLAGS_UPD <= flags_mask(op_q);
                    FLAG_V    <= op_def & ALU_OF;
`ifdef ALU_SEQ_DECIMAL_EN
                    if (dec_pass) begin
                        // N/Z wait for the corrected result in ADJ.
                        FLAG_C  <= dec_c;
                        drv_q   <= adj_drive(ALU_RESULT, corr);
                        state_q <= ST_ADJ;
                    end else
`endif
                    begin
                        FLAG_C  <= op_def & ALU_COUT;
                        RESULT  <= exec_result;
                        // N/Z come from the ALU sum, which covers CMP too.
                        FLAG_N  <= op_def & ALU_RESULT[7];
                        FLAG_Z  <= op_def & (ALU_RESULT == 8'h00);
                        drv_q   <= '0;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                        state_q <= ST_FIN;
                    end
                end
`ifdef ALU_SEQ_DECIMAL_EN
                ST_ADJ: begin
                    RESULT  <= ALU_RESULT;
                    FLAG_N  <= ALU_RESULT[7];
                    FLAG_Z  <= (ALU_RESULT == 8'h00);
                    drv_q   <= '0;
                    BUSY    <= 1'b0;
                    DONE    <= 1'b1;
                    state_q <= ST_FIN;
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table-driven bench for alu_sequencer with a behavioural
// 6502 ALU closing the loop. Decimal expectations follow ALU_SEQ_DECIMAL_EN.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic       START = 1'b0;
    logic [3:0] OP    = '0;
    logic [7:0] OPA   = '0;
    logic [7:0] OPB   = '0;
    logic       CIN   = 1'b0;
    logic       DMODE = 1'b0;

    logic       BUSY, DONE, FLAG_N, FLAG_V, FLAG_Z, FLAG_C;
    logic [7:0] RESULT, ALU_A, ALU_B;
    logic [3:0] FLAGS_UPD;
    logic       ALU_SUMS, ALU_ANDS, ALU_ORS, ALU_EORS, ALU_SRS, ALU_BCDS, ALU_CIN;
    logic [7:0] ALU_RESULT;
    logic       ALU_OF, ALU_COUT, ALU_HCOUT;

    alu_sequencer dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP), .OPA(OPA), .OPB(OPB),
        .CIN(CIN), .DMODE(DMODE), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT),
        .FLAG_N(FLAG_N), .FLAG_V(FLAG_V), .FLAG_Z(FLAG_Z), .FLAG_C(FLAG_C),
        .FLAGS_UPD(FLAGS_UPD), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_SUMS(ALU_SUMS), .ALU_ANDS(ALU_ANDS), .ALU_ORS(ALU_ORS),
        .ALU_EORS(ALU_EORS), .ALU_SRS(ALU_SRS), .ALU_BCDS(ALU_BCDS),
        .ALU_CIN(ALU_CIN), .ALU_RESULT(ALU_RESULT), .ALU_OF(ALU_OF),
        .ALU_COUT(ALU_COUT), .ALU_HCOUT(ALU_HCOUT)
    );

    // ---------------- behavioural ALU ----------------
    logic [8:0] m_sum;
    logic [4:0] m_half;
    always_comb begin
        m_sum      = {1'b0, ALU_A} + {1'b0, ALU_B} + {8'h00, ALU_CIN};
        m_half     = {1'b0, ALU_A[3:0]} + {1'b0, ALU_B[3:0]} + {4'h0, ALU_CIN};
        ALU_RESULT = 8'h00;
        ALU_COUT   = 1'b0;
        ALU_HCOUT  = 1'b0;
        ALU_OF     = 1'b0;
        if (ALU_SUMS) begin
            ALU_RESULT = m_sum[7:0];
            ALU_COUT   = m_sum[8];
            ALU_HCOUT  = m_half[4];
            ALU_OF     = (ALU_A[7] == ALU_B[7]) && (m_sum[7] != ALU_A[7]);
        end else if (ALU_ANDS) begin
            ALU_RESULT = ALU_A & ALU_B;
        end else if (ALU_ORS) begin
            ALU_RESULT = ALU_A | ALU_B;
        end else if (ALU_EORS) begin
            ALU_RESULT = ALU_A ^ ALU_B;
        end else if (ALU_SRS) begin
            ALU_RESULT = {ALU_CIN, ALU_A[7:1]};
            ALU_COUT   = ALU_A[0];
        end
    end

    logic [40:0] all_out;
    assign all_out = {BUSY, DONE, RESULT, FLAG_N, FLAG_V, FLAG_Z, FLAG_C, FLAGS_UPD,
                      ALU_A, ALU_B, ALU_SUMS, ALU_ANDS, ALU_ORS, ALU_EORS, ALU_SRS,
                      ALU_BCDS, ALU_CIN};

    // ---------------- scoreboard ----------------
    int checks = 0;
    int fails  = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe exclusivity and BCDS held low, sampled away from the active edge.
    always @(negedge CLK) begin
        if (!RST) begin
            checks++;
            if (!$onehot0({ALU_SUMS, ALU_ANDS, ALU_ORS, ALU_EORS, ALU_SRS}) || ALU_BCDS) begin
                fails++;
                $display("FAIL strobes: got %b expected onehot0 and bcds=0",
                         {ALU_SUMS, ALU_ANDS, ALU_ORS, ALU_EORS, ALU_SRS, ALU_BCDS});
            end
        end
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       dm;
        logic [7:0] res;
        logic [3:0] nvzc;
        logic [3:0] upd;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic cin, input logic dm, input logic [7:0] res,
                                input logic [3:0] nvzc, input logic [3:0] upd, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.cin = cin; v.dm = dm;
        v.res = res; v.nvzc = nvzc; v.upd = upd; v.lat = lat;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic run_vec(input string tag, input vec_t v);
        int         cyc;
        logic [7:0] exp_res;
        @(negedge CLK);
        OP = v.op; OPA = v.a; OPB = v.b; CIN = v.cin; DMODE = v.dm; START = 1'b1;
        exp_q.push_back(v.res);
        @(posedge CLK);
        #1 START = 1'b0;
        cyc = 1;
        while (!DONE && cyc < 8) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(v.lat));
        exp_res = exp_q.pop_front();
        check({tag, " result"}, 64'(RESULT), 64'(exp_res));
        check({tag, " flags"}, 64'({FLAG_N, FLAG_V, FLAG_Z, FLAG_C} & v.upd), 64'(v.nvzc & v.upd));
        check({tag, " flags_upd"}, 64'(FLAGS_UPD), 64'(v.upd));
        @(posedge CLK);
        #1;
        check({tag, " done pulse"}, 64'(DONE), 64'(0));
    endtask

    task automatic count_done(input string tag, input int n);
        int dn;
        dn = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
            if (DONE) dn++;
        end
        check({tag, " stray done"}, 64'(dn), 64'(0));
    endtask

    // Start a decimal ADC, assert reset after `edges` clock edges.
    task automatic reset_mid(input string tag, input int edges);
        @(negedge CLK);
        OP = OP_ADC; OPA = 8'h09; OPB = 8'h01; CIN = 1'b0; DMODE = 1'b1; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        for (int k = 1; k < edges; k++) begin
            @(posedge CLK);
            #1;
        end
        check({tag, " busy before reset"}, 64'(BUSY), 64'(1));
        RST = 1'b1;
        #1;
        check({tag, " outputs in reset"}, 64'(all_out), 64'(0));
        @(negedge CLK);
        RST = 1'b0;
        count_done(tag, 4);
        run_vec({tag, " after"}, mk(OP_INC, 8'h41, 8'h00, 1'b0, 1'b0, 8'h42, 4'b0000, UPD_NZ, 2));
    endtask

    // ---------------- test ----------------
    initial begin
        vecs.push_back(mk(OP_ADC, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 4'b1100, UPD_NVZC, 2));
        vecs.push_back(mk(OP_SBC, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 4'b1000, UPD_NVZC, 2));
        vecs.push_back(mk(OP_AND, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 4'b0000, UPD_NZ,   2));
        vecs.push_back(mk(OP_ORA, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 4'b0010, UPD_NZ,   2));
        vecs.push_back(mk(OP_EOR, 8'hFF, 8'h0F, 1'b0, 1'b0, 8'hF0, 4'b1000, UPD_NZ,   2));
        vecs.push_back(mk(OP_LSR, 8'h81, 8'h00, 1'b1, 1'b0, 8'h40, 4'b0001, UPD_NZC,  2));
        vecs.push_back(mk(OP_ROR, 8'h01, 8'h00, 1'b1, 1'b0, 8'h80, 4'b1001, UPD_NZC,  2));
        vecs.push_back(mk(OP_ASL, 8'h80, 8'h00, 1'b1, 1'b0, 8'h00, 4'b0011, UPD_NZC,  2));
        vecs.push_back(mk(OP_ROL, 8'h40, 8'h00, 1'b1, 1'b0, 8'h81, 4'b1000, UPD_NZC,  2));
        vecs.push_back(mk(OP_CMP, 8'h40, 8'h40, 1'b0, 1'b0, 8'h40, 4'b0011, UPD_NZC,  2));
        vecs.push_back(mk(OP_CMP, 8'h10, 8'h20, 1'b1, 1'b0, 8'h10, 4'b1000, UPD_NZC,  2));
        vecs.push_back(mk(OP_INC, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0010, UPD_NZ,   2));
        vecs.push_back(mk(OP_DEC, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 4'b1000, UPD_NZ,   2));
        vecs.push_back(mk(4'hF,   8'h5A, 8'h33, 1'b1, 1'b0, 8'h5A, 4'b0000, UPD_NONE, 2));
        vecs.push_back(mk(OP_ADC, 8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 4'b1100, UPD_NVZC, 2));
        vecs.push_back(mk(OP_AND, 8'hAA, 8'h0F, 1'b0, 1'b1, 8'h0A, 4'b0000, UPD_NZ,   2));
`ifdef ALU_SEQ_DECIMAL_EN
        vecs.push_back(mk(OP_ADC, 8'h09, 8'h01, 1'b0, 1'b1, 8'h10, 4'b0000, UPD_NVZC, 3));
        vecs.push_back(mk(OP_ADC, 8'h99, 8'h01, 1'b0, 1'b1, 8'h00, 4'b0011, UPD_NVZC, 3));
        vecs.push_back(mk(OP_SBC, 8'h10, 8'h01, 1'b1, 1'b1, 8'h09, 4'b0001, UPD_NVZC, 3));
`else
        vecs.push_back(mk(OP_ADC, 8'h09, 8'h01, 1'b0, 1'b1, 8'h0A, 4'b0000, UPD_NVZC, 2));
        vecs.push_back(mk(OP_ADC, 8'h99, 8'h01, 1'b0, 1'b1, 8'h9A, 4'b1000, UPD_NVZC, 2));
        vecs.push_back(mk(OP_SBC, 8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 4'b0001, UPD_NVZC, 2));
`endif

        repeat (3) @(posedge CLK);
        #1;
        check("reset outputs", 64'(all_out), 64'(0));
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("idle after reset", 64'({BUSY, DONE}), 64'(0));

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // START while BUSY is ignored.
        @(negedge CLK);
        OP = OP_ADC; OPA = 8'h01; OPB = 8'h01; CIN = 1'b0; DMODE = 1'b0; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        check("busy in exec", 64'(BUSY), 64'(1));
        @(negedge CLK);
        OPA = 8'h10; OPB = 8'h10; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        check("busy-start done", 64'(DONE), 64'(1));
        check("busy-start result", 64'(RESULT), 64'(8'h02));
        count_done("busy-start", 4);

        // Back-to-back: START accepted in FIN.
        @(negedge CLK);
        OP = OP_ADC; OPA = 8'h01; OPB = 8'h02; CIN = 1'b0; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        @(posedge CLK);
        #1;
        check("b2b first done", 64'(DONE), 64'(1));
        check("b2b first result", 64'(RESULT), 64'(8'h03));
        OP = OP_INC; OPA = 8'h7F; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        check("b2b accepted", 64'({BUSY, DONE}), 64'(2'b10));
        @(posedge CLK);
        #1;
        check("b2b second done", 64'(DONE), 64'(1));
        check("b2b second result", 64'(RESULT), 64'(8'h80));
        check("b2b second flags", 64'({FLAG_N, FLAG_Z}), 64'(2'b10));
        @(posedge CLK);
        #1;

        reset_mid("rst exec", 1);
`ifdef ALU_SEQ_DECIMAL_EN
        reset_mid("rst adj", 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
